// File: rtl/sb_split_slave.sv
// Split-capable memory slave: serves a word array and parks unlocked reads behind a SPLIT
// response, later asking the arbiter (sb_split) to re-grant the parked master.
module sb_split_slave #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 200,
   parameter int unsigned SPLIT_WAIT = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sb_sel,
   input  logic [ADDR_WIDTH-1:0] sb_addr,
   input  logic [1:0]            sb_trans,
   input  logic                  sb_write,
   input  logic [DATA_WIDTH-1:0] sb_wdata,
   input  logic [1:0]            sb_masters,
   input  logic                  sb_mastlock,
   output logic                  sb_ready,
   output logic [1:0]            sb_resp,
   output logic [DATA_WIDTH-1:0] sb_rdata,
   output logic [1:0]            sb_split
);

   localparam int unsigned CntW = $clog2(SPLIT_WAIT + 1);
   localparam logic [CntW-1:0]     CntLoad  = CntW'(SPLIT_WAIT);
   localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   localparam logic [1:0] RespOkay  = 2'b00;
   localparam logic [1:0] RespError = 2'b01;
   localparam logic [1:0] RespRetry = 2'b10;
   localparam logic [1:0] RespSplit = 2'b11;

   typedef enum logic [1:0] {StAddr, StData, StResp1, StResp2} bus_st_e;
   typedef enum logic [1:0] {TrkNone, TrkWait, TrkRelease, TrkHeld} trk_st_e;

   bus_st_e               bus_q, bus_d;
   trk_st_e               trk_q, trk_d;
   logic [1:0]            resp_q, resp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [1:0]            pend_mst_q, pend_mst_d;
   logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  accept;
   logic                  commit;
   logic                  in_range;
   logic                  mst_ok;
   logic [DATA_WIDTH-1:0] mem_word;
   logic [DATA_WIDTH-1:0] rd_fwd;
   logic [DATA_WIDTH-1:0] buf_fwd;
   logic                  buf_hit;
   logic [1:0]            code;

   assign sb_ready = (bus_q != StResp1);
   assign sb_resp  = (bus_q == StResp1 || bus_q == StResp2) ? resp_q : RespOkay;
   assign sb_rdata = rdata_q;
   assign sb_split = (trk_q == TrkRelease) ? pend_mst_q : 2'b00;

   assign accept   = sb_ready && sb_sel && sb_trans[1];
   assign commit   = (bus_q == StData) && wr_q;
   assign in_range = {1'b0, sb_addr} < DepthLim;
   assign mst_ok   = (sb_masters == 2'b01) || (sb_masters == 2'b10);
   assign mem_word = in_range ? mem[sb_addr] : '0;
   // A write finishing on the same edge as a read of that word must be seen by the read.
   assign rd_fwd   = (commit && waddr_q == sb_addr) ? sb_wdata : mem_word;
   assign buf_hit  = commit && (trk_q != TrkNone) && (waddr_q == pend_addr_q);
   assign buf_fwd  = buf_hit ? sb_wdata : buf_q;

   always_comb begin
      bus_d       = bus_q;
      trk_d       = trk_q;
      resp_d      = resp_q;
      rdata_d     = rdata_q;
      wr_d        = 1'b0;
      waddr_d     = waddr_q;
      cnt_d       = cnt_q;
      pend_mst_d  = pend_mst_q;
      pend_addr_d = pend_addr_q;
      buf_d       = buf_q;
      code        = RespOkay;

      case (trk_q)
         TrkWait: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) trk_d = TrkRelease;
            end
         end
         TrkRelease: trk_d = TrkHeld;
         default: ;
      endcase

      // The wait only starts once the SPLIT response has fully gone out.
      if (bus_q == StResp2 && resp_q == RespSplit) cnt_d = CntLoad;

      if (buf_hit) buf_d = sb_wdata;

      case (bus_q)
         StResp1: bus_d = StResp2;
         default: bus_d = StAddr;
      endcase

      if (accept) begin
         if (!in_range || !mst_ok) begin
            code = RespError;
         end else if (sb_mastlock) begin
            code = RespOkay;
            if (sb_write) begin
               wr_d    = 1'b1;
               waddr_d = sb_addr;
            end else begin
               rdata_d = rd_fwd;
            end
         end else if (trk_q == TrkHeld && sb_masters == pend_mst_q && !sb_write &&
                      sb_addr == pend_addr_q) begin
            code    = RespOkay;
            rdata_d = buf_fwd;
            trk_d   = TrkNone;
            cnt_d   = '0;
         end else if (trk_q != TrkNone && sb_masters != pend_mst_q) begin
            code = RespRetry;
         end else if (!sb_write) begin
            // Any earlier split from this master is replaced by the new one.
            code        = RespSplit;
            trk_d       = TrkWait;
            cnt_d       = '0;
            pend_mst_d  = sb_masters;
            pend_addr_d = sb_addr;
            buf_d       = rd_fwd;
         end else begin
            code    = RespOkay;
            trk_d   = TrkNone;
            cnt_d   = '0;
            wr_d    = 1'b1;
            waddr_d = sb_addr;
         end
         resp_d = code;
         bus_d  = (code == RespOkay) ? StData : StResp1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus_q       <= StAddr;
         trk_q       <= TrkNone;
         resp_q      <= RespOkay;
         rdata_q     <= '0;
         wr_q        <= 1'b0;
         waddr_q     <= '0;
         cnt_q       <= '0;
         pend_mst_q  <= 2'b00;
         pend_addr_q <= '0;
         buf_q       <= '0;
      end else begin
         bus_q       <= bus_d;
         trk_q       <= trk_d;
         resp_q      <= resp_d;
         rdata_q     <= rdata_d;
         wr_q        <= wr_d;
         waddr_q     <= waddr_d;
         cnt_q       <= cnt_d;
         pend_mst_q  <= pend_mst_d;
         pend_addr_q <= pend_addr_d;
         buf_q       <= buf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && commit) mem[waddr_q] <= sb_wdata;
   end

endmodule

// File: tb/tb_sb_split_slave.sv
// Directed bench for sb_split_slave: per-cycle expectations go through a scoreboard queue and
// are compared one cycle later against the bus outputs.
module tb_sb_split_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        sb_sel;
   logic [7:0]  sb_addr;
   logic [1:0]  sb_trans;
   logic        sb_write;
   logic [31:0] sb_wdata;
   logic [1:0]  sb_masters;
   logic        sb_mastlock;
   logic        sb_ready;
   logic [1:0]  sb_resp;
   logic [31:0] sb_rdata;
   logic [1:0]  sb_split;

   always #5 clk = ~clk;

   sb_split_slave #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .MEM_DEPTH (200),
      .SPLIT_WAIT(6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sb_sel     (sb_sel),
      .sb_addr    (sb_addr),
      .sb_trans   (sb_trans),
      .sb_write   (sb_write),
      .sb_wdata   (sb_wdata),
      .sb_masters (sb_masters),
      .sb_mastlock(sb_mastlock),
      .sb_ready   (sb_ready),
      .sb_resp    (sb_resp),
      .sb_rdata   (sb_rdata),
      .sb_split   (sb_split)
   );

   typedef struct packed {
      logic        ready;
      logic [1:0]  resp;
      logic [1:0]  split;
      logic        chk_rd;
      logic [31:0] rdata;
   } exp_t;

   exp_t  sb_q[$];
   int    compared   = 0;
   int    mismatched = 0;
   string step       = "init";

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s/%s: observed %h expected %h", step, tag, obs, exp);
      end
   endtask

   // Queue the expected outputs for after the next edge, advance, then compare.
   task automatic tick(input logic rdy, input logic [1:0] rsp, input logic [1:0] spl,
                       input logic chk_rd, input logic [31:0] rd);
      exp_t e;
      e.ready  = rdy;
      e.resp   = rsp;
      e.split  = spl;
      e.chk_rd = chk_rd;
      e.rdata  = rd;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("ready", 32'(sb_ready), 32'(e.ready));
      check("resp", 32'(sb_resp), 32'(e.resp));
      check("split", 32'(sb_split), 32'(e.split));
      if (e.chk_rd) check("rdata", sb_rdata, e.rdata);
   endtask

   task automatic idle();
      sb_sel   = 1'b0;
      sb_trans = 2'b00;
   endtask

   task automatic xfer(input logic [1:0] mst, input logic [7:0] addr, input logic wr,
                       input logic lock);
      sb_sel      = 1'b1;
      sb_trans    = 2'b10;
      sb_masters  = mst;
      sb_addr     = addr;
      sb_write    = wr;
      sb_mastlock = lock;
   endtask

   initial begin
      rst         = 1'b0;
      sb_sel      = 1'b0;
      sb_addr     = '0;
      sb_trans    = 2'b00;
      sb_write    = 1'b0;
      sb_wdata    = '0;
      sb_masters  = 2'b01;
      sb_mastlock = 1'b0;

      step = "reset";
      tick(1'b1, 2'b00, 2'b00, 1'b1, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b1, 32'h0);
      rst  = 1'b1;
      step = "idle";
      for (int i = 0; i < 5; i++) tick(1'b1, 2'b00, 2'b00, 1'b1, 32'h0);

      step = "locked_wr_rd";
      xfer(2'b01, 8'h10, 1'b1, 1'b1);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      sb_wdata = 32'hDEADBEEF;
      xfer(2'b01, 8'h10, 1'b0, 1'b1);
      tick(1'b1, 2'b00, 2'b00, 1'b1, 32'hDEADBEEF);
      idle();
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);

      step = "split";
      xfer(2'b10, 8'h10, 1'b0, 1'b0);
      tick(1'b0, 2'b11, 2'b00, 1'b0, 32'h0);
      idle();
      tick(1'b1, 2'b11, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      step = "retry_in_wait";
      xfer(2'b01, 8'h20, 1'b0, 1'b0);
      tick(1'b0, 2'b10, 2'b00, 1'b0, 32'h0);
      idle();
      tick(1'b1, 2'b10, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      step = "split_pulse";
      tick(1'b1, 2'b00, 2'b10, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      step = "split_complete";
      xfer(2'b10, 8'h10, 1'b0, 1'b0);
      tick(1'b1, 2'b00, 2'b00, 1'b1, 32'hDEADBEEF);
      idle();
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);

      step = "err_range_rd";
      xfer(2'b01, 8'd200, 1'b0, 1'b0);
      tick(1'b0, 2'b01, 2'b00, 1'b0, 32'h0);
      idle();
      tick(1'b1, 2'b01, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      step = "err_mst_rd";
      xfer(2'b11, 8'h10, 1'b0, 1'b0);
      tick(1'b0, 2'b01, 2'b00, 1'b0, 32'h0);
      idle();
      tick(1'b1, 2'b01, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      step = "err_mst_wr";
      xfer(2'b11, 8'h10, 1'b1, 1'b1);
      tick(1'b0, 2'b01, 2'b00, 1'b0, 32'h0);
      sb_wdata = 32'h12345678;
      idle();
      tick(1'b1, 2'b01, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      step = "err_range_wr";
      xfer(2'b01, 8'd250, 1'b1, 1'b0);
      tick(1'b0, 2'b01, 2'b00, 1'b0, 32'h0);
      sb_wdata = 32'h55555555;
      idle();
      tick(1'b1, 2'b01, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      step = "mem_unchanged";
      xfer(2'b01, 8'h10, 1'b0, 1'b1);
      tick(1'b1, 2'b00, 2'b00, 1'b1, 32'hDEADBEEF);
      idle();
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);

      step = "reset_mid_split";
      xfer(2'b01, 8'h30, 1'b0, 1'b0);
      tick(1'b0, 2'b11, 2'b00, 1'b0, 32'h0);
      idle();
      tick(1'b1, 2'b11, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      rst = 1'b0;
      tick(1'b1, 2'b00, 2'b00, 1'b1, 32'h0);
      rst  = 1'b1;
      step = "no_pulse_after_reset";
      for (int i = 0; i < 10; i++) tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      step = "fresh_split";
      xfer(2'b01, 8'h10, 1'b0, 1'b0);
      tick(1'b0, 2'b11, 2'b00, 1'b0, 32'h0);
      idle();
      tick(1'b1, 2'b11, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b01, 1'b0, 32'h0);
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      xfer(2'b01, 8'h10, 1'b0, 1'b0);
      tick(1'b1, 2'b00, 2'b00, 1'b1, 32'hDEADBEEF);
      idle();
      tick(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sb_split_slave.md
Name: sb_split_slave

Overview:
- Split-capable memory slave on the system bus: the responder end of the arbiter's split handshake.
- Serves reads and writes to an internal word array.
- Answers unlocked reads with a SPLIT response and captures the data later. It then signals the arbiter on sb_split to re-grant the parked master, and completes the master's retried read with OKAY.
- Sits behind the address decoder, in parallel with the other slaves; its sb_split and sb_resp feed the arbiter's split/response inputs.

Parameters:
ADDR_WIDTH, 8, word-address width of sb_addr
DATA_WIDTH, 32, read/write data width
MEM_DEPTH, 200, implemented words; addresses >= MEM_DEPTH are out of range
SPLIT_WAIT, 6, cycles between end of SPLIT response and sb_split pulse (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (low = reset)
sb_sel  in  1  slave select from the address decoder
sb_addr  in  ADDR_WIDTH  word address, address phase
sb_trans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
sb_write  in  1  1 = write, 0 = read
sb_wdata  in  DATA_WIDTH  write data, data phase
sb_masters  in  2  one-hot owner of the address phase (01 = m1, 10 = m2)
sb_mastlock  in  1  current transfer is locked
sb_ready  out  1  transfer done / slave ready for a new address phase
sb_resp  out  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
sb_rdata  out  DATA_WIDTH  read data, valid with sb_ready=1 and OKAY
sb_split  out  2  one-hot un-split request to the arbiter, 1-cycle pulse

Behaviour:
- Reset (rst=0 at an edge):
  - Outputs: sb_ready=1, sb_resp=00, sb_rdata=0, sb_split=00.
  - Internal: bus FSM=ADDR, split tracker=NONE, wait counter=0, pending master/address cleared.
  - A reset mid-split drops the pending split with no sb_split pulse.
  - Memory contents are not reset.
- Address phase accepted at an edge where sb_ready=1, sb_sel=1 and sb_trans is 10 or 11. IDLE, BUSY or sb_sel=0 means no action and sb_ready=1/OKAY.
- Bus FSM states: ADDR, DATA, RESP1, RESP2.
  - Accepted transfer, normal case → DATA, one cycle, sb_ready=1, sb_resp=OKAY.
    - Read: sb_rdata is the word registered at the accept edge.
    - Write: the word is written at the end-of-DATA edge using sb_wdata.
    - A new address phase may be accepted at that same edge (pipelined).
  - Accepted transfer with a non-OKAY result → RESP1 (sb_ready=0, sb_resp=code), then RESP2 (sb_ready=1, sb_resp=code), then ADDR.
    - Address inputs are ignored while sb_ready=0.
    - No memory write occurs for non-OKAY transfers.
- Response selection, in priority order:
  1. sb_addr >= MEM_DEPTH, or sb_masters not one-hot → ERROR.
  2. sb_mastlock=1 → OKAY, never split or retried.
     - A locked write to the pending address also updates the split buffer.
  3. Tracker HELD, master == pending master, read, address == pending address → OKAY with buffered data; tracker → NONE.
  4. Tracker != NONE and master != pending master → RETRY.
  5. Tracker != NONE and same master on any other access → drop the pending split, then evaluate as from NONE.
  6. Tracker NONE, read → SPLIT; latch master, address and memory word into the buffer; tracker → WAIT.
  7. Tracker NONE, write → OKAY.
- Split tracker states: NONE, WAIT, RELEASE, HELD.
  - WAIT: the counter is loaded with SPLIT_WAIT at the edge ending RESP2, then decrements each cycle.
  - Counter reaches 0 → RELEASE for exactly one cycle, with sb_split = pending master. sb_split therefore rises exactly SPLIT_WAIT cycles after the RESP2 cycle.
  - RELEASE → HELD. HELD persists until rule 3 or 5 fires, or reset.
- An unlocked write to the pending address from the pending master is covered by rule 5: the split is dropped.
- At most one outstanding split; sb_split is never 11.

Test Plan:
- Reset then idle: rst=0 two cycles → sb_ready=1, sb_resp=00, sb_split=00, sb_rdata=0; sb_trans=00 for 5 cycles → no change.
- Locked write/read: m1 locked write 0xDEADBEEF @0x10, then locked read @0x10 → write OKAY in 1 data cycle; read sb_rdata=0xDEADBEEF, OKAY, sb_ready never low.
- Split round trip: m2 unlocked read @0x10 → RESP1 (ready=0, resp=11), RESP2 (ready=1, resp=11); sb_split=10 for exactly 1 cycle, SPLIT_WAIT=6 cycles after RESP2; m2 re-reads @0x10 → OKAY, 0xDEADBEEF, 0 waits.
- Retry while pending: during the WAIT from the previous case, m1 unlocked read @0x20 → two-cycle RETRY (10); the pending m2 split is unaffected and its sb_split pulse timing is unchanged.
- Error paths: read @200 (≥MEM_DEPTH) → two-cycle ERROR (01); read with sb_masters=11 → ERROR; write @250 → ERROR and no memory change.
- Reset mid-split: rst=0 for 1 cycle during WAIT → no sb_split pulse ever; the next m1 read @0x10 is split afresh (resp=11).
